// File: rtl/snake_seg_pkg.sv
// Shared types and constants for the 74HC595 score scanner: FSM states,
// frame geometry and the active-low 7-segment code table.
package snake_seg_pkg;

    typedef enum logic [1:0] {
        LOAD,
        SHIFT,
        LATCH,
        HOLD
    } state_t;

    localparam int NUM_DIGITS = 6;
    localparam int SEG_BITS   = 8;
    localparam int FRAME_BITS = 14;
    localparam int SEL_BITS   = FRAME_BITS - SEG_BITS;

    localparam logic [SEG_BITS-1:0] SEG_BLANK = 8'hFF;
    localparam logic [SEG_BITS-1:0] SEG_DASH  = 8'hBF;

    // Entry n is the {dp,g,f,e,d,c,b,a} pattern for decimal digit n.
    localparam logic [9:0][SEG_BITS-1:0] SEG_TABLE = {
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
        8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [SEG_BITS-1:0] digit_code(input logic [3:0] nibble);
        return (nibble > 4'd9) ? SEG_DASH : SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD nibble to active-low segment pattern, with blanking.
module seg7_encode
    import snake_seg_pkg::*;
(
    input  logic [3:0]          nibble,
    input  logic                blank,
    output logic [SEG_BITS-1:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            seg = digit_code(nibble);
        end
    end

endmodule

// File: rtl/hc595_score_scan.sv
// Scans a 3-digit BCD score onto a 6-digit multiplexed display through two
// cascaded 74HC595s, one 14-bit {seg, sel} frame per digit.
module hc595_score_scan
    import snake_seg_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int DIGIT_HOLD = 50_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] bcd_data,
    input  logic        disp_en,
    output logic        shcp,
    output logic        stcp,
    output logic        ds,
    output logic        oe,
    output logic        sweep_done
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HOLD_W = (DIGIT_HOLD > 1) ? $clog2(DIGIT_HOLD) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(DIGIT_HOLD - 1);
    localparam logic [2:0]        LAST_DIGIT = 3'(NUM_DIGITS - 1);
    localparam logic [3:0]        LAST_BIT   = 4'(FRAME_BITS - 1);

    state_t                  state;
    logic [DIV_W-1:0]        div_cnt;
    logic [3:0]              bit_cnt;
    logic [HOLD_W-1:0]       hold_cnt;
    logic [2:0]              digit_idx;
    logic [11:0]             snapshot;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic                    lit;

    logic [11:0]             score;
    logic [3:0]              nibble;
    logic                    blank;
    logic [SEG_BITS-1:0]     seg;
    logic [FRAME_BITS-1:0]   frame;

    // Digit 0 is built in the same cycle the snapshot is taken, so it sees bcd_data directly.
    assign score = (digit_idx == 3'd0) ? bcd_data : snapshot;

    always_comb begin
        nibble = score[3:0];
        blank  = 1'b1;
        case (digit_idx)
            3'd0: blank = 1'b0;
            3'd1: begin
                nibble = score[7:4];
                blank  = (score[11:8] == 4'd0) && (score[7:4] == 4'd0);
            end
            3'd2: begin
                nibble = score[11:8];
                blank  = (score[11:8] == 4'd0);
            end
            default: blank = 1'b1;
        endcase
    end

    seg7_encode u_encode (
        .nibble (nibble),
        .blank  (blank),
        .seg    (seg)
    );

    assign frame = {seg, SEL_BITS'(1) << digit_idx};

    // Once the first frame has been latched, oe follows disp_en with one cycle of latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= LOAD;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            hold_cnt   <= '0;
            digit_idx  <= '0;
            snapshot   <= '0;
            shift_reg  <= '0;
            lit        <= 1'b0;
            shcp       <= 1'b0;
            stcp       <= 1'b0;
            ds         <= 1'b0;
            oe         <= 1'b1;
            sweep_done <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            if (lit) begin
                oe <= ~disp_en;
            end
            case (state)
                LOAD: begin
                    if (digit_idx == 3'd0) begin
                        snapshot <= bcd_data;
                    end
                    ds        <= frame[FRAME_BITS-1];
                    shift_reg <= {frame[FRAME_BITS-2:0], 1'b0};
                    bit_cnt   <= '0;
                    div_cnt   <= '0;
                    shcp      <= 1'b0;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!shcp) begin
                            shcp <= 1'b1;
                        end else if (bit_cnt == LAST_BIT) begin
                            shcp  <= 1'b0;
                            ds    <= 1'b0;
                            stcp  <= 1'b1;
                            state <= LATCH;
                        end else begin
                            shcp      <= 1'b0;
                            ds        <= shift_reg[FRAME_BITS-1];
                            shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end
                    end
                end
                LATCH: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt    <= '0;
                        stcp       <= 1'b0;
                        lit        <= 1'b1;
                        oe         <= ~disp_en;
                        sweep_done <= (digit_idx == LAST_DIGIT);
                        hold_cnt   <= '0;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end else begin
                        digit_idx <= (digit_idx == LAST_DIGIT) ? 3'd0 : digit_idx + 3'd1;
                        state     <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_hc595_score_scan.sv
// Self-checking bench: deserialises ds on shcp rising, captures frames on stcp
// rising and compares them with a digit-level model of the display rules.
module tb_hc595_score_scan;

    localparam int PERIOD = 1 + 28 + 1 + 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] bcd_data = '0;
    logic        disp_en = 1'b0;
    logic        shcp, stcp, ds, oe, sweep_done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int next_idx = 0;

    logic [13:0] sreg = '0;
    logic [13:0] cap_q[$];
    int          sweep_q[$];
    bit          oe_low_seen = 1'b0;

    always #5 clk = ~clk;

    hc595_score_scan #(
        .CLK_DIV    (1),
        .DIGIT_HOLD (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_data   (bcd_data),
        .disp_en    (disp_en),
        .shcp       (shcp),
        .stcp       (stcp),
        .ds         (ds),
        .oe         (oe),
        .sweep_done (sweep_done)
    );

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge shcp) sreg <= {sreg[12:0], ds};
    always @(posedge stcp) cap_q.push_back(sreg);

    always @(negedge clk) begin
        if (sweep_done === 1'b1) sweep_q.push_back(cyc);
        if (oe !== 1'b1) oe_low_seen = 1'b1;
    end

    function automatic logic [7:0] seg_of(input int n, input bit blank);
        if (blank) return 8'hFF;
        case (n)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hBF;
        endcase
    endfunction

    // What the two 595s should hold for display position idx, given the sweep's score.
    function automatic logic [13:0] model_frame(input logic [11:0] snap, input int idx);
        int h, t, o;
        logic [7:0] seg;
        logic [5:0] sel;
        h = int'(snap[11:8]);
        t = int'(snap[7:4]);
        o = int'(snap[3:0]);
        case (idx)
            0: seg = seg_of(o, 1'b0);
            1: seg = seg_of(t, (h == 0) && (t == 0));
            2: seg = seg_of(h, h == 0);
            default: seg = 8'hFF;
        endcase
        sel = '0;
        sel[idx] = 1'b1;
        return {seg, sel};
    endfunction

    task automatic get_frame(output logic [13:0] w, output int idx);
        bit ok;
        ok = 1'b0;
        w = '0;
        idx = next_idx;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cap_q.size() > 0) begin
                w = cap_q.pop_front();
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("[TB] FAIL frame_timeout idx=%0d got=no stcp rise in 200 cycles expected=one frame", idx);
        end
        next_idx = (next_idx + 1) % 6;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        bcd_data = 12'h123;
        disp_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (shcp !== 1'b0) begin bad++; $display("[TB] FAIL reset_shcp got=%b expected=0", shcp); end
        total++; if (stcp !== 1'b0) begin bad++; $display("[TB] FAIL reset_stcp got=%b expected=0", stcp); end
        total++; if (ds !== 1'b0) begin bad++; $display("[TB] FAIL reset_ds got=%b expected=0", ds); end
        total++; if (oe !== 1'b1) begin bad++; $display("[TB] FAIL reset_oe got=%b expected=1", oe); end
        total++; if (sweep_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_sweep_done got=%b expected=0", sweep_done); end
        cap_q.delete();
        sweep_q.delete();
        next_idx = 0;
        rst_n = 1'b1;
        // One LOAD cycle plus one low-phase cycle before the first shift clock rises.
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (shcp === 1'b1) break;
        end
        total++; if (n !== 2) begin bad++; $display("[TB] FAIL first_shcp_rise got=%0d edges expected=2", n); end
    endtask

    task automatic test_sweep();
        logic [13:0] w;
        int idx;
        for (int k = 0; k < 12; k++) begin
            get_frame(w, idx);
            total++;
            if (w !== model_frame(12'h123, idx)) begin
                bad++;
                $display("[TB] FAIL sweep_frame idx=%0d got=%h expected=%h", idx, w, model_frame(12'h123, idx));
            end
            if (k == 0) begin
                total++; if (oe !== 1'b1) begin bad++; $display("[TB] FAIL oe_before_first_latch got=%b expected=1", oe); end
                @(negedge clk);
                total++; if (oe !== 1'b0) begin bad++; $display("[TB] FAIL oe_after_first_latch got=%b expected=0", oe); end
            end
        end
        repeat (2) @(negedge clk);
        total++;
        if (sweep_q.size() !== 2) begin
            bad++;
            $display("[TB] FAIL sweep_done_count got=%0d expected=2", sweep_q.size());
        end else begin
            total++;
            if (sweep_q[1] - sweep_q[0] !== 6 * PERIOD) begin
                bad++;
                $display("[TB] FAIL sweep_done_spacing got=%0d expected=%0d", sweep_q[1] - sweep_q[0], 6 * PERIOD);
            end
        end
    endtask

    task automatic test_blanking();
        logic [11:0] vals [3];
        logic [13:0] w;
        int idx;
        vals = '{12'h007, 12'h070, 12'h0A5};
        foreach (vals[v]) begin
            bcd_data = vals[v];
            for (int k = 0; k < 6; k++) begin
                get_frame(w, idx);
                total++;
                if (w !== model_frame(vals[v], idx)) begin
                    bad++;
                    $display("[TB] FAIL blank_frame bcd=%h idx=%0d got=%h expected=%h", vals[v], idx, w, model_frame(vals[v], idx));
                end
            end
        end
    endtask

    task automatic test_snapshot();
        logic [13:0] w;
        int idx;
        bcd_data = 12'h123;
        get_frame(w, idx);
        total++;
        if (w !== model_frame(12'h123, idx)) begin
            bad++;
            $display("[TB] FAIL snap_frame idx=%0d got=%h expected=%h", idx, w, model_frame(12'h123, idx));
        end
        // Lands inside the SHIFT phase of digit 1.
        repeat (8) @(negedge clk);
        bcd_data = 12'h456;
        for (int k = 0; k < 11; k++) begin
            get_frame(w, idx);
            total++;
            if (w !== model_frame((k < 5) ? 12'h123 : 12'h456, idx)) begin
                bad++;
                $display("[TB] FAIL snap_frame idx=%0d got=%h expected=%h", idx, w,
                         model_frame((k < 5) ? 12'h123 : 12'h456, idx));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [13:0] w;
        int idx;
        for (int k = 0; k < 2; k++) begin
            get_frame(w, idx);
            total++;
            if (w !== model_frame(12'h456, idx)) begin
                bad++;
                $display("[TB] FAIL pre_reset_frame idx=%0d got=%h expected=%h", idx, w, model_frame(12'h456, idx));
            end
        end
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (shcp !== 1'b0) begin bad++; $display("[TB] FAIL midreset_shcp got=%b expected=0", shcp); end
        total++; if (stcp !== 1'b0) begin bad++; $display("[TB] FAIL midreset_stcp got=%b expected=0", stcp); end
        total++; if (ds !== 1'b0) begin bad++; $display("[TB] FAIL midreset_ds got=%b expected=0", ds); end
        total++; if (oe !== 1'b1) begin bad++; $display("[TB] FAIL midreset_oe got=%b expected=1", oe); end
        total++; if (cap_q.size() !== 0) begin bad++; $display("[TB] FAIL midreset_no_latch got=%0d frames expected=0", cap_q.size()); end
        cap_q.delete();
        next_idx = 0;
        oe_low_seen = 1'b0;
        disp_en = 1'b0;
        bcd_data = 12'h908;
        rst_n = 1'b1;
        get_frame(w, idx);
        total++;
        if (w !== model_frame(12'h908, 0)) begin
            bad++;
            $display("[TB] FAIL restart_frame got=%h expected=%h", w, model_frame(12'h908, 0));
        end
        repeat (2) @(negedge clk);
        total++; if (oe_low_seen !== 1'b0) begin bad++; $display("[TB] FAIL oe_dark_after_reset got=low seen expected=always 1"); end
    endtask

    task automatic test_random();
        logic [13:0] w;
        logic [11:0] snap;
        logic [3:0]  nib [3];
        logic        en;
        int idx;
        snap = 12'h908;
        for (int k = 0; k < 24; k++) begin
            get_frame(w, idx);
            total++;
            if (w !== model_frame(snap, idx)) begin
                bad++;
                $display("[TB] FAIL rand_frame idx=%0d snap=%h got=%h expected=%h", idx, snap, w, model_frame(snap, idx));
            end
            for (int j = 0; j < 3; j++) begin
                nib[j] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            end
            bcd_data = {nib[2], nib[1], nib[0]};
            if (next_idx == 0) snap = bcd_data;
            en = 1'($urandom_range(0, 1));
            disp_en = en;
            @(negedge clk);
            total++;
            if (oe !== ~en) begin
                bad++;
                $display("[TB] FAIL rand_oe disp_en=%b got=%b expected=%b", en, oe, ~en);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_blanking();
        test_snapshot();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
